pwm_capture: RTL and testbench

Receive-side counterpart of the fan controller's PWM output. It synchronises an external PWM signal, measures high time and period in clk_en ticks, and publishes each completed period with a one-cycle valid strobe. The strobe uses the same semantics as the controller's data-valid input. Used for closed-loop self-test (PWM_pin looped back) and for reading duty from an external PWM-type sensor.

---
 rtl/pwm_capture_if.sv | 26 ++
 rtl/pwm_capture.sv | 151 +++++++++++++++
 tb/tb_pwm_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: one-cycle valid strobe plus the
// measured high time, period and timeout flag that it qualifies.
interface pwm_capture_if #(
    parameter int CNT_BITWIDTH = 5
) ();
    logic                    dataVaild_STRB_o;
    logic [CNT_BITWIDTH-1:0] high_o;
    logic [CNT_BITWIDTH-1:0] period_o;
    logic                    timeout_o;

    // The capture block drives the results.
    modport master (
        output dataVaild_STRB_o,
        output high_o,
        output period_o,
        output timeout_o
    );

    // The consumer only observes them.
    modport slave (
        input dataVaild_STRB_o,
        input high_o,
        input period_o,
        input timeout_o
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an external PWM pin, measures high time and
// period in clk_en ticks, and publishes each completed rise-to-rise period
// (or a saturation timeout) with a one-cycle strobe.
module pwm_capture #(
    parameter int CNT_BITWIDTH = 5,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clk_en_i,
    input  logic          PWM_pin_i,
    pwm_capture_if.master res_o,
    output logic [1:0]    state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0]  sync_q;
    logic [SYNC_STAGES-1:0]  sync_d;
    state_t                  state_q;
    logic                    s_prev_q;
    logic [CNT_BITWIDTH-1:0] per_q;
    logic [CNT_BITWIDTH-1:0] hi_q;
    logic                    strobe_q;
    logic [CNT_BITWIDTH-1:0] high_q;
    logic [CNT_BITWIDTH-1:0] period_q;
    logic                    timeout_q;

    // Synchroniser chain: stage 0 samples the pin, later stages shift.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = PWM_pin_i;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    // Synchroniser advances every clock, independent of the tick enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    logic                    s_d;
    logic                    rise_d;
    logic                    fall_d;
    logic                    per_max_d;
    logic                    timeout_d;
    logic [CNT_BITWIDTH-1:0] per_inc_d;
    logic [CNT_BITWIDTH-1:0] hi_inc_d;
    logic [CNT_BITWIDTH-1:0] to_high_d;

    assign s_d       = sync_q[SYNC_STAGES-1];
    assign rise_d    = s_d & ~s_prev_q;
    assign fall_d    = ~s_d & s_prev_q;
    assign per_max_d = (per_q == CNT_MAX);
    // Any edge on a saturated tick pre-empts the timeout (rise wins).
    assign timeout_d = per_max_d & ~rise_d & ~fall_d;
    assign per_inc_d = per_max_d ? CNT_MAX : per_q + CNT_ONE;
    assign hi_inc_d  = (hi_q == CNT_MAX) ? CNT_MAX : hi_q + CNT_ONE;
    // Stuck high reports full-scale high time; stuck low keeps what was seen.
    assign to_high_d = s_d ? CNT_MAX : hi_q;

    // Measurement FSM with registered results; only enabled ticks advance it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            s_prev_q  <= 1'b0;
            per_q     <= '0;
            hi_q      <= '0;
            strobe_q  <= 1'b0;
            high_q    <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clk_en_i) begin
                s_prev_q <= s_d;
                if (timeout_d) begin
                    high_q    <= to_high_d;
                    period_q  <= CNT_MAX;
                    timeout_q <= 1'b1;
                    strobe_q  <= 1'b1;
                    state_q   <= IDLE;
                    per_q     <= '0;
                    hi_q      <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (rise_d) begin
                                state_q <= HIGH;
                                per_q   <= CNT_ONE;
                                hi_q    <= CNT_ONE;
                            end else if (fall_d) begin
                                // Level changed: restart the constant-level run.
                                per_q <= CNT_ONE;
                            end else begin
                                per_q <= per_inc_d;
                            end
                        end
                        HIGH: begin
                            if (fall_d) begin
                                state_q <= LOW;
                                per_q   <= per_inc_d;
                            end else begin
                                per_q <= per_inc_d;
                                hi_q  <= hi_inc_d;
                            end
                        end
                        LOW: begin
                            if (rise_d) begin
                                high_q    <= hi_q;
                                period_q  <= per_q;
                                timeout_q <= 1'b0;
                                strobe_q  <= 1'b1;
                                state_q   <= HIGH;
                                per_q     <= CNT_ONE;
                                hi_q      <= CNT_ONE;
                            end else begin
                                per_q <= per_inc_d;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            per_q   <= '0;
                            hi_q    <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign res_o.dataVaild_STRB_o = strobe_q;
    assign res_o.high_o           = high_q;
    assign res_o.period_o         = period_q;
    assign res_o.timeout_o        = timeout_q;
    assign state_o                = state_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of steady PWM vectors plus
// hand-written reset, saturation and mid-period reset sequences.
module tb_pwm_capture;
    localparam int W = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       pin;
    logic [1:0] state;

    pwm_capture_if #(.CNT_BITWIDTH(W)) res_if ();

    pwm_capture #(
        .CNT_BITWIDTH(W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .PWM_pin_i(pin),
        .res_o    (res_if),
        .state_o  (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int div      = 1;

    typedef struct {
        int cyc;
        int high;
        int period;
        int timeout;
    } rec_t;

    typedef struct {
        int hi;
        int per;
        int dv;
        int exp_hi;
        int exp_per;
        int exp_lat;
    } vec_t;

    rec_t rec_q[$];
    int   rise_q[$];
    logic prev_strobe = 1'b0;
    vec_t vecs[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: record every result, check width and tick alignment.
    always @(posedge clk) begin
        #1;
        if (res_if.dataVaild_STRB_o === 1'b1) begin
            check("strobe_width", 32'(prev_strobe), 32'd0);
            check("strobe_on_tick", 32'(clk_en), 32'd1);
            rec_q.push_back('{cyc, int'(res_if.high_o), int'(res_if.period_o), int'(res_if.timeout_o)});
            $display("strobe cyc=%0d high=%0d period=%0d timeout=%0b",
                     cyc, res_if.high_o, res_if.period_o, res_if.timeout_o);
        end
        prev_strobe = res_if.dataVaild_STRB_o;
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b1;
        pin    = 1'b0;
        clk_en = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        rec_q.delete();
        rise_q.delete();
    endtask

    // Hold the pin at a level for n ticks; each tick is div clocks with
    // the enable asserted on its first clock.
    task automatic drive(input logic level, input int nticks);
        for (int t = 0; t < nticks; t++) begin
            for (int j = 0; j < div; j++) begin
                @(negedge clk);
                if (j == 0 && level && !pin) rise_q.push_back(cyc);
                pin    = level;
                clk_en = (j == 0);
            end
        end
    endtask

    task automatic pwm(input int hi, input int per, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, hi);
            drive(1'b0, per - hi);
        end
    endtask

    initial begin
        // {high, period, clocks per tick, exp high, exp period, exp latency}
        vecs = '{
            '{7,  19, 1,  7,  19, 3},
            '{3,  19, 1,  3,  19, 3},
            '{8,  19, 1,  8,  19, 3},
            '{15, 19, 1,  15, 19, 3},
            '{1,  2,  1,  1,  2,  3},
            '{5,  31, 1,  5,  31, 3},
            '{30, 31, 1,  30, 31, 3},
            '{7,  19, 10, 7,  19, 11}
        };

        // Reset held 3 cycles while the pin toggles.
        rst    = 1'b1;
        pin    = 1'b0;
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'({res_if.dataVaild_STRB_o, res_if.high_o, res_if.period_o,
                                        res_if.timeout_o, state}), 32'd0);
            pin = ~pin;
        end
        rst = 1'b0;
        pin = 1'b0;
        @(negedge clk);
        check("post_reset_strobe", 32'(res_if.dataVaild_STRB_o), 32'd0);
        check("post_reset_state", 32'(state), 32'd0);

        // Steady PWM vectors: 4 periods plus a closing rise -> 4 results.
        foreach (vecs[v]) begin
            div = vecs[v].dv;
            do_reset(2);
            pwm(vecs[v].hi, vecs[v].per, 4);
            drive(1'b1, 1);
            drive(1'b0, 5);
            check($sformatf("v%0d_count", v), rec_q.size(), 4);
            for (int i = 0; i < rec_q.size() && i < 4; i++) begin
                check($sformatf("v%0d_r%0d_high", v, i), rec_q[i].high, vecs[v].exp_hi);
                check($sformatf("v%0d_r%0d_period", v, i), rec_q[i].period, vecs[v].exp_per);
                check($sformatf("v%0d_r%0d_timeout", v, i), rec_q[i].timeout, 0);
                check($sformatf("v%0d_r%0d_latency", v, i), rec_q[i].cyc - rise_q[i+1], vecs[v].exp_lat);
            end
        end

        // Constant high: timeouts at full scale, 32 ticks apart.
        div = 1;
        do_reset(2);
        drive(1'b1, 100);
        check("const1_count", rec_q.size(), 3);
        for (int i = 0; i < rec_q.size(); i++) begin
            check($sformatf("const1_r%0d_high", i), rec_q[i].high, 31);
            check($sformatf("const1_r%0d_period", i), rec_q[i].period, 31);
            check($sformatf("const1_r%0d_timeout", i), rec_q[i].timeout, 1);
        end
        if (rec_q.size() >= 2)
            check("const1_spacing", rec_q[1].cyc - rec_q[0].cyc, 32);

        // Constant low after that: zero high time with timeout.
        rec_q.delete();
        drive(1'b0, 70);
        check("const0_count", rec_q.size(), 2);
        for (int i = 0; i < rec_q.size(); i++) begin
            check($sformatf("const0_r%0d_high", i), rec_q[i].high, 0);
            check($sformatf("const0_r%0d_period", i), rec_q[i].period, 31);
            check($sformatf("const0_r%0d_timeout", i), rec_q[i].timeout, 1);
        end

        // Recovery into 3/19 PWM: normal results with timeout cleared.
        rec_q.delete();
        rise_q.delete();
        pwm(3, 19, 2);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check("recover_count", rec_q.size(), 2);
        for (int i = 0; i < rec_q.size(); i++) begin
            check($sformatf("recover_r%0d_high", i), rec_q[i].high, 3);
            check($sformatf("recover_r%0d_period", i), rec_q[i].period, 19);
            check($sformatf("recover_r%0d_timeout", i), rec_q[i].timeout, 0);
        end

        // Reset during the HIGH phase abandons the measurement.
        do_reset(2);
        pwm(7, 19, 2);
        drive(1'b1, 5);
        check("mid_state_high", 32'(state), 32'd1);
        rec_q.delete();
        rst = 1'b1;
        drive(1'b1, 2);
        drive(1'b0, 2);
        rst = 1'b0;
        rise_q.delete();
        drive(1'b0, 3);
        pwm(7, 19, 1);
        check("mid_no_strobe_one_rise", rec_q.size(), 0);
        drive(1'b1, 1);
        drive(1'b0, 5);
        check("mid_count", rec_q.size(), 1);
        if (rec_q.size() == 1) begin
            check("mid_high", rec_q[0].high, 7);
            check("mid_period", rec_q[0].period, 19);
            check("mid_timeout", rec_q[0].timeout, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
